// File: rtl/cen_mean_acc.sv
// Multi-channel block accumulator: sums 2^LOG2_N signed samples per channel and
// emits the exact block sum and the round-half-up block mean for each channel.
module cen_mean_acc #(
    parameter int unsigned CH     = 4,
    parameter int unsigned DW     = 26,
    parameter int unsigned LOG2_N = 10,
    localparam int unsigned AW    = DW + LOG2_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DW-1:0]     x_in,
    output logic [CH*AW-1:0]     sum_out,
    output logic [CH*DW-1:0]     mean_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic [LOG2_N-1:0]    cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        MEAN = 2'd2
    } state_t;

    // Rounding offset: half of one LSB of the mean
    localparam logic signed [AW-1:0] HALF = AW'(1) << (LOG2_N - 1);

    state_t               state;
    logic signed [AW-1:0] acc [CH];
    logic                 accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sum_out   <= '0;
            mean_out  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            for (int c = 0; c < int'(CH); c++) acc[c] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                cnt      <= '0;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                for (int c = 0; c < int'(CH); c++) acc[c] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= ACC;
                            cnt      <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            for (int c = 0; c < int'(CH); c++) acc[c] <= '0;
                        end
                    end
                    ACC: begin
                        if (accept) begin
                            for (int c = 0; c < int'(CH); c++)
                                acc[c] <= acc[c] + AW'($signed(x_in[c*DW +: DW]));
                            cnt <= cnt + LOG2_N'(1);
                            // Last sample of the block: cnt wraps to zero here
                            if (cnt == {LOG2_N{1'b1}}) begin
                                state    <= MEAN;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                    MEAN: begin
                        for (int c = 0; c < int'(CH); c++) begin
                            sum_out[c*AW +: AW]  <= acc[c];
                            mean_out[c*DW +: DW] <= DW'((acc[c] + HALF) >>> LOG2_N);
                        end
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cen_mean_acc.sv
// Directed bench for cen_mean_acc with CH=4, DW=26, LOG2_N=2.
module tb_cen_mean_acc;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 26;
    localparam int unsigned LG = 2;
    localparam int unsigned AW = DW + LG;

    logic              clk;
    logic              rst;
    logic              start;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [CH*DW-1:0]  x_in;
    logic [CH*AW-1:0]  sum_out;
    logic [CH*DW-1:0]  mean_out;
    logic              out_valid;
    logic              busy;
    logic [LG-1:0]     cnt;

    int vecs = 0;
    int errs = 0;

    cen_mean_acc #(.CH(CH), .DW(DW), .LOG2_N(LG)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .sum_out(sum_out), .mean_out(mean_out), .out_valid(out_valid),
        .busy(busy), .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH*DW-1:0] px(input int a0, input int a1, input int a2, input int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic logic [CH*AW-1:0] ps(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input int a0, input int a1, input int a2, input int a3);
        x_in     = px(a0, a1, a2, a3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; x_in = '0;
        #12;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_sum", 128'(sum_out), 128'(0));
        chk("rst_mean", 128'(mean_out), 128'(0));
        rst = 1'b0;
        tick();

        // Basic block, back-to-back samples
        do_start();
        chk("start_in_ready", 128'(in_ready), 128'(1));
        chk("start_busy", 128'(busy), 128'(1));
        chk("start_cnt", 128'(cnt), 128'(0));
        feed(1, -4, 0, 1);
        feed(2, -4, 0, 0);
        feed(3, -4, 0, 0);
        feed(4, -5, 0, 1);
        chk("b1_ready_drop", 128'(in_ready), 128'(0));
        chk("b1_ov_early", 128'(out_valid), 128'(0));
        tick();
        chk("b1_ov", 128'(out_valid), 128'(1));
        chk("b1_sum", 128'(sum_out), 128'(ps(10, -17, 0, 2)));
        chk("b1_mean", 128'(mean_out), 128'(px(3, -4, 0, 1)));
        chk("b1_busy", 128'(busy), 128'(0));
        tick();
        chk("b1_ov_once", 128'(out_valid), 128'(0));

        // Positive extreme
        do_start();
        repeat (4) feed(33554431, 33554431, 33554431, 33554431);
        tick();
        chk("maxp_sum", 128'(sum_out), 128'(ps(134217724, 134217724, 134217724, 134217724)));
        chk("maxp_mean", 128'(mean_out), 128'(px(33554431, 33554431, 33554431, 33554431)));

        // Negative extreme
        do_start();
        repeat (4) feed(-33554432, -33554432, -33554432, -33554432);
        tick();
        chk("maxn_sum", 128'(sum_out), 128'(ps(-134217728, -134217728, -134217728, -134217728)));
        chk("maxn_mean", 128'(mean_out), 128'(px(-33554432, -33554432, -33554432, -33554432)));
        tick();

        // Samples offered in IDLE must be ignored
        x_in = px(100, 100, 100, 100); in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        chk("idle_cnt", 128'(cnt), 128'(0));

        // Backpressure 1,0,0,1,1,0,1 with a stray start during ACC
        do_start();
        feed(1, -4, 0, 1);
        chk("bp_cnt1", 128'(cnt), 128'(1));
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("bp_cnt_hold", 128'(cnt), 128'(1));
        chk("bp_ready_hold", 128'(in_ready), 128'(1));
        feed(2, -4, 0, 0);
        chk("bp_cnt2", 128'(cnt), 128'(2));
        feed(3, -4, 0, 0);
        chk("bp_cnt3", 128'(cnt), 128'(3));
        tick();
        feed(4, -5, 0, 1);
        chk("bp_cnt_wrap", 128'(cnt), 128'(0));
        tick();
        chk("bp_ov", 128'(out_valid), 128'(1));
        chk("bp_sum", 128'(sum_out), 128'(ps(10, -17, 0, 2)));
        chk("bp_mean", 128'(mean_out), 128'(px(3, -4, 0, 1)));
        tick();

        // Clear after two accepts
        do_start();
        feed(7, 7, 7, 7);
        feed(7, 7, 7, 7);
        chk("clr_cnt2", 128'(cnt), 128'(2));
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_ready", 128'(in_ready), 128'(0));
        chk("clr_busy", 128'(busy), 128'(0));
        chk("clr_cnt", 128'(cnt), 128'(0));
        tick();
        chk("clr_no_ov", 128'(out_valid), 128'(0));
        chk("clr_mean_kept", 128'(mean_out), 128'(px(3, -4, 0, 1)));

        // Full block after clear
        do_start();
        feed(5, -1, 3, -2);
        feed(5, -1, -3, -2);
        feed(5, -1, 3, -2);
        feed(6, -1, -3, -1);
        tick();
        chk("pc_ov", 128'(out_valid), 128'(1));
        chk("pc_sum", 128'(sum_out), 128'(ps(21, -4, 0, -7)));
        chk("pc_mean", 128'(mean_out), 128'(px(5, -1, 0, -2)));

        // Restart with start during the out_valid cycle
        start = 1'b1; tick(); start = 1'b0;
        chk("rs_ready", 128'(in_ready), 128'(1));
        chk("rs_cnt", 128'(cnt), 128'(0));
        repeat (4) feed(2, 2, 2, 2);
        tick();
        chk("rs_ov", 128'(out_valid), 128'(1));
        chk("rs_sum", 128'(sum_out), 128'(ps(8, 8, 8, 8)));
        chk("rs_mean", 128'(mean_out), 128'(px(2, 2, 2, 2)));
        tick();

        // Asynchronous reset after three accepts
        do_start();
        repeat (3) feed(9, 9, 9, 9);
        chk("ar_cnt3", 128'(cnt), 128'(3));
        #3 rst = 1'b1;
        #1;
        chk("ar_ready", 128'(in_ready), 128'(0));
        chk("ar_busy", 128'(busy), 128'(0));
        chk("ar_cnt", 128'(cnt), 128'(0));
        chk("ar_sum", 128'(sum_out), 128'(0));
        chk("ar_mean", 128'(mean_out), 128'(0));
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("ar_no_ov", 128'(out_valid), 128'(0));
        tick();
        chk("ar_no_ov2", 128'(out_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
